// File: rtl/ring_decoder_if.sv
// ring_decoder_if: sample/result bundle for ring_decoder.
//   master: drives en, d, clr_cnt; observes the decoded results.
//   slave : the decoder; consumes samples, drives idx, pulses, locked, err_cnt.
interface ring_decoder_if #(
  parameter int N     = 4,
  parameter int ERR_W = 8
);
  localparam int W = $clog2(N);

  logic             en;
  logic [N-1:0]     d;
  logic             clr_cnt;
  logic [W-1:0]     idx;
  logic             idx_valid;
  logic             onehot_err;
  logic             seq_err;
  logic             locked;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output en, d, clr_cnt,
    input  idx, idx_valid, onehot_err, seq_err, locked, err_cnt
  );

  modport slave (
    input  en, d, clr_cnt,
    output idx, idx_valid, onehot_err, seq_err, locked, err_cnt
  );
endinterface

// File: rtl/ring_decoder.sv
// ring_decoder: decodes an N-bit one-hot ring vector to a binary index, checks
// that the hot bit advances by one (N-1 wraps to 0) on every enabled sample,
// tracks sequence lock and keeps a saturating error count.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : ring_decoder_if.slave (en, d, clr_cnt in; idx, idx_valid,
//              onehot_err, seq_err, locked, err_cnt out). All outputs registered.
//
// state  | meaning
// HUNT   | no reference; first legal sample seeds ref
// ACQ    | counting consecutive correct steps toward LOCK_CNT
// LOCKED | ref flywheels every sample; LOSS_CNT consecutive errors drop to HUNT
module ring_decoder #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 2,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input logic          clk,
  input logic          rst,
  ring_decoder_if.slave bus
);
  localparam int W  = $clog2(N);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);
  localparam logic [W-1:0]     LAST    = W'(N - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     ref_q, ref_d;
  logic [RW-1:0]    run_q, run_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic [W-1:0]     idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             onehot_err_q, onehot_err_d;
  logic             seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic         any_hot, multi_hot, legal, correct;
  logic [W-1:0] pos, exp_idx;
  logic [RW-1:0] run_inc;
  logic [MW-1:0] miss_inc;

  // Single pass: multi_hot sets once a second hot bit is seen.
  always_comb begin
    any_hot   = 1'b0;
    multi_hot = 1'b0;
    pos       = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.d[i]) begin
        multi_hot = multi_hot | any_hot;
        any_hot   = 1'b1;
        pos       = W'(i);
      end
    end
  end

  assign legal    = any_hot & ~multi_hot;
  assign exp_idx  = (ref_q == LAST) ? '0 : ref_q + W'(1);
  assign correct  = legal && (pos == exp_idx);
  assign run_inc  = run_q + RW'(1);
  assign miss_inc = miss_q + MW'(1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      case (state_q)
        HUNT:    if (legal) state_d = ACQ;
        ACQ: begin
          if (!legal)                                 state_d = HUNT;
          else if (correct && run_inc == RW'(LOCK_CNT)) state_d = LOCKED;
        end
        LOCKED:  if (!correct && miss_inc == MW'(LOSS_CNT)) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    ref_d        = ref_q;
    run_d        = run_q;
    miss_d       = miss_q;
    idx_d        = idx_q;
    idx_valid_d  = 1'b0;
    onehot_err_d = 1'b0;
    seq_err_d    = 1'b0;
    if (bus.en) begin
      idx_valid_d  = legal;
      onehot_err_d = ~legal;
      if (legal) idx_d = pos;
      case (state_q)
        HUNT: begin
          if (legal) begin
            ref_d = pos;
            run_d = '0;
          end
        end
        ACQ: begin
          if (legal) begin
            ref_d = pos;
            if (correct) begin
              run_d = run_inc;
              if (run_inc == RW'(LOCK_CNT)) miss_d = '0;
            end else begin
              seq_err_d = 1'b1;
              run_d     = '0;
            end
          end
        end
        LOCKED: begin
          ref_d = exp_idx;
          if (correct) begin
            miss_d = '0;
          end else begin
            seq_err_d = legal;
            miss_d    = miss_inc;
          end
        end
        default: ;
      endcase
    end
    // Clear wins over a same-cycle increment; clear acts regardless of en.
    if (bus.clr_cnt)                                      err_d = '0;
    else if ((onehot_err_d | seq_err_d) && err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
    else                                                  err_d = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q        <= '0;
      run_q        <= '0;
      miss_q       <= '0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      onehot_err_q <= 1'b0;
      seq_err_q    <= 1'b0;
      err_q        <= '0;
    end else begin
      ref_q        <= ref_d;
      run_q        <= run_d;
      miss_q       <= miss_d;
      idx_q        <= idx_d;
      idx_valid_q  <= idx_valid_d;
      onehot_err_q <= onehot_err_d;
      seq_err_q    <= seq_err_d;
      err_q        <= err_d;
    end
  end

  assign bus.idx        = idx_q;
  assign bus.idx_valid  = idx_valid_q;
  assign bus.onehot_err = onehot_err_q;
  assign bus.seq_err    = seq_err_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.err_cnt    = err_q;
endmodule

// File: tb/tb_ring_decoder.sv
// Bench for ring_decoder: directed scenarios plus random stimulus, checked
// against a behavioural model. A second instance with ERR_W=2 sees identical
// stimulus so counter saturation is exercised cheaply.
module tb_ring_decoder;
  localparam int N        = 4;
  localparam int LOCK_CNT = 2;
  localparam int LOSS_CNT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ring_decoder_if #(.N(N), .ERR_W(8)) bus ();
  ring_decoder_if #(.N(N), .ERR_W(2)) bus2 ();

  ring_decoder #(.N(N), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(8))
    dut (.clk(clk), .rst(rst), .bus(bus));
  ring_decoder #(.N(N), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode 0=hunt 1=acquire 2=locked
  int mode, mref, mrun, mmiss, midx, merr, merr2;
  bit mvalid, moh, mseq;

  function automatic logic [15:0] obs();
    return {bus.idx, bus.idx_valid, bus.onehot_err, bus.seq_err, bus.locked,
            bus.err_cnt, bus2.err_cnt};
  endfunction

  function automatic logic [15:0] expv();
    return {2'(midx), mvalid, moh, mseq, (mode == 2), 8'(merr), 2'(merr2)};
  endfunction

  task automatic model_reset();
    mode = 0; mref = 0; mrun = 0; mmiss = 0; midx = 0;
    merr = 0; merr2 = 0; mvalid = 0; moh = 0; mseq = 0;
  endtask

  task automatic model_step(input bit e, input logic [N-1:0] dv, input bit c);
    int ones, p, ex;
    bit flag;
    mvalid = 0; moh = 0; mseq = 0; flag = 0;
    if (e) begin
      ones = 0; p = 0;
      for (int i = 0; i < N; i++) if (dv[i]) begin ones++; p = i; end
      ex = (mref + 1) % N;
      if (ones == 1) begin mvalid = 1; midx = p; end
      else moh = 1;
      case (mode)
        0: if (ones == 1) begin mref = p; mrun = 0; mode = 1; end
        1: begin
          if (ones != 1) mode = 0;
          else if (p == ex) begin
            mref = p; mrun++;
            if (mrun == LOCK_CNT) begin mode = 2; mmiss = 0; end
          end else begin
            mseq = 1; mref = p; mrun = 0;
          end
        end
        default: begin
          mref = ex;
          if (ones == 1 && p == ex) mmiss = 0;
          else begin
            if (ones == 1) mseq = 1;
            mmiss++;
            if (mmiss == LOSS_CNT) mode = 0;
          end
        end
      endcase
      flag = moh | mseq;
    end
    if (c) begin merr = 0; merr2 = 0; end
    else if (flag) begin
      if (merr < 255) merr++;
      if (merr2 < 3) merr2++;
    end
  endtask

  task automatic step(input bit e, input logic [N-1:0] dv, input bit c);
    bus.en = e;  bus.d = dv;  bus.clr_cnt = c;
    bus2.en = e; bus2.d = dv; bus2.clr_cnt = c;
    @(posedge clk);
    #1;
    model_step(e, dv, c);
  endtask

  task automatic apply_reset(input bit e, input logic [N-1:0] dv, input bit c);
    rst = 1'b1;
    bus.en = e;  bus.d = dv;  bus.clr_cnt = c;
    bus2.en = e; bus2.d = dv; bus2.clr_cnt = c;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset(1'b1, 4'b0011, 1'b1);
    n_checks++;
    if (obs() !== 16'h0000) $display("FAIL reset got=%h exp=%h", obs(), 16'h0000);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [N-1:0] seq [5];
    int exp_idx [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_idx = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      step(1'b1, seq[k], 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL basic[%0d] got=%h exp=%h", k, obs(), expv());
      else n_pass++;
      n_checks++;
      if (bus.idx !== 2'(exp_idx[k]) || bus.idx_valid !== 1'b1 || bus.err_cnt !== 8'd0 ||
          bus.locked !== (k >= 2))
        $display("FAIL basic_direct[%0d] got idx=%0d v=%b lk=%b err=%0d exp idx=%0d v=1 lk=%b err=0",
                 k, bus.idx, bus.idx_valid, bus.locked, bus.err_cnt, exp_idx[k], (k >= 2));
      else n_pass++;
    end
  endtask

  task automatic test_onehot_locked();
    logic [N-1:0] seq [3];
    seq = '{4'b0010, 4'b0110, 4'b1000};
    for (int k = 0; k < 3; k++) begin
      step(1'b1, seq[k], 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL onehot_locked[%0d] got=%h exp=%h", k, obs(), expv());
      else n_pass++;
      if (k == 1) begin
        n_checks++;
        if (bus.onehot_err !== 1'b1 || bus.err_cnt !== 8'd1 || bus.idx !== 2'd1 || bus.locked !== 1'b1)
          $display("FAIL onehot_locked_direct got oh=%b err=%0d idx=%0d lk=%b exp oh=1 err=1 idx=1 lk=1",
                   bus.onehot_err, bus.err_cnt, bus.idx, bus.locked);
        else n_pass++;
      end
    end
  endtask

  task automatic test_loss();
    logic [N-1:0] seq [5];
    seq = '{4'b0000, 4'b0011, 4'b0001, 4'b0010, 4'b0100};
    for (int k = 0; k < 5; k++) begin
      step(1'b1, seq[k], 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL loss[%0d] got=%h exp=%h", k, obs(), expv());
      else n_pass++;
    end
  endtask

  task automatic test_skip();
    logic [N-1:0] seq [4];
    seq = '{4'b1000, 4'b0001, 4'b0100, 4'b0100};
    for (int k = 0; k < 4; k++) begin
      step(1'b1, seq[k], 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL skip[%0d] got=%h exp=%h", k, obs(), expv());
      else n_pass++;
      if (k == 2) begin
        n_checks++;
        if (bus.seq_err !== 1'b1 || bus.idx !== 2'd2 || bus.locked !== 1'b1)
          $display("FAIL skip_direct got seq=%b idx=%0d lk=%b exp seq=1 idx=2 lk=1",
                   bus.seq_err, bus.idx, bus.locked);
        else n_pass++;
      end
    end
  endtask

  task automatic test_saturate();
    apply_reset(1'b0, '0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, (k % 2 == 0) ? 4'b0000 : 4'b1111, (k == 5));
      n_checks++;
      if (obs() !== expv()) $display("FAIL saturate[%0d] got=%h exp=%h", k, obs(), expv());
      else n_pass++;
    end
    n_checks++;
    if (bus2.err_cnt !== 2'd0 || bus.err_cnt !== 8'd0)
      $display("FAIL saturate_clear got err=%0d err2=%0d exp err=0 err2=0", bus.err_cnt, bus2.err_cnt);
    else n_pass++;
  endtask

  task automatic test_en_low();
    apply_reset(1'b0, '0, 1'b0);
    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0010, 1'b0);
    step(1'b1, 4'b0100, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      n_checks++;
      if (obs() !== expv() || bus.locked !== 1'b1 || bus.idx_valid !== 1'b0)
        $display("FAIL en_low[%0d] got=%h exp=%h", k, obs(), expv());
      else n_pass++;
    end
    step(1'b1, 4'b1000, 1'b0);
    n_checks++;
    if (obs() !== expv()) $display("FAIL en_resume got=%h exp=%h", obs(), expv());
    else n_pass++;
    apply_reset(1'b1, 4'b0011, 1'b0);
    n_checks++;
    if (obs() !== 16'h0000) $display("FAIL reset_locked got=%h exp=%h", obs(), 16'h0000);
    else n_pass++;
  endtask

  task automatic test_back_to_back_random();
    logic [N-1:0] dv;
    int r;
    bit e, c;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      dv = 4'(1 << ((mref + 1) % N));
      else if (r < 85) dv = 4'(1 << $urandom_range(0, N - 1));
      else             dv = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 149) == 0) apply_reset(e, dv, c);
      else step(e, dv, c);
      n_checks++;
      if (obs() !== expv()) $display("FAIL random[%0d] got=%h exp=%h", k, obs(), expv());
      else n_pass++;
    end
  endtask

  initial begin
    bus.en = 1'b0;  bus.d = '0;  bus.clr_cnt = 1'b0;
    bus2.en = 1'b0; bus2.d = '0; bus2.clr_cnt = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_onehot_locked();
    test_loss();
    test_skip();
    test_saturate();
    test_en_low();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
